// File: rtl/ai_mc_rx_deserializer_if.sv
// Output word stream of the receive deserializer: registered head word and valid
// from the 2-entry buffer, ready from the read-data FIFO.
interface ai_mc_rx_deserializer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/ai_mc_rx_deserializer.sv
// Receive deserializer for the SPI/Dual/Quad read path.
// Skips dummy beats, assembles DATA_W-bit words from 1/2/4 lanes (MSB- or
// LSB-first) and hands them to a 2-entry registered output buffer.
// Optional macro AI_MC_RX_DESER_BYTE_SWAP_EN adds a byte_swap input that
// byte-reverses each completed word before it is buffered.
module ai_mc_rx_deserializer #(
  parameter int DATA_W    = 32,
  parameter int MAX_LANES = 4,
  parameter int WCNT_W    = 16,
  parameter int DCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 lsb_first,
  input  logic [WCNT_W-1:0]    xfer_words,
  input  logic [DCNT_W-1:0]    dummy_beats,
  input  logic                 sample_strobe,
  input  logic [MAX_LANES-1:0] miso,
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
  input  logic                 byte_swap,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  ai_mc_rx_deserializer_if.master out_if
);

  localparam int BCNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DUMMY  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          mode_reg;
  logic                lsb_reg;
  logic [WCNT_W-1:0]   xfer_reg;
  logic [DCNT_W-1:0]   dummy_cnt_reg;
  logic [BCNT_W-1:0]   beat_cnt_reg;
  logic [WCNT_W-1:0]   word_cnt_reg;
  logic [DATA_W-1:0]   sreg_reg;
  logic [DATA_W-1:0]   head_reg, tail_reg;
  logic                head_vld_reg, tail_vld_reg;
  logic                overflow_reg;

  logic                start_acc;
  logic                strobe_shift;
  logic                last_beat;
  logic                last_word;
  logic [BCNT_W-1:0]   beat_max;
  logic [DATA_W-1:0]   sreg_shift;
  logic [DATA_W-1:0]   word_swapped;
  logic [DATA_W-1:0]   word_push;
  logic                push, pop;

  // A start is only honoured while idle; anything else is a busy-time start.
  assign start_acc    = (state_reg == ST_IDLE) && start;
  assign strobe_shift = (state_reg == ST_SHIFT) && sample_strobe;
  assign last_beat    = strobe_shift && (beat_cnt_reg == beat_max);
  assign last_word    = (word_cnt_reg == (xfer_reg - WCNT_W'(1)));

  // Last beat index of a word for the latched lane mode (reserved mode = 1 lane).
  always_comb begin
    case (mode_reg)
      2'd1:    beat_max = BCNT_W'(DATA_W / 2 - 1);
      2'd2:    beat_max = BCNT_W'(DATA_W / 4 - 1);
      default: beat_max = BCNT_W'(DATA_W - 1);
    endcase
  end

  // Shift register value after absorbing the current beat's lanes.
  always_comb begin
    case (mode_reg)
      2'd1:    sreg_shift = lsb_reg ? {miso[1:0], sreg_reg[DATA_W-1:2]}
                                    : {sreg_reg[DATA_W-3:0], miso[1:0]};
      2'd2:    sreg_shift = lsb_reg ? {miso[3:0], sreg_reg[DATA_W-1:4]}
                                    : {sreg_reg[DATA_W-5:0], miso[3:0]};
      default: sreg_shift = lsb_reg ? {miso[0], sreg_reg[DATA_W-1:1]}
                                    : {sreg_reg[DATA_W-2:0], miso[0]};
    endcase
  end

  // Byte-reversed view of the completed word; bit order inside a byte is kept.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_swap
    assign word_swapped[gi*8 +: 8] = sreg_shift[DATA_W-8-gi*8 +: 8];
  end

`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
  logic swap_reg;
  // Byte-swap selection is latched with the rest of the transfer config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            swap_reg <= 1'b0;
    else if (start_acc) swap_reg <= byte_swap;
  end
  assign word_push = swap_reg ? word_swapped : sreg_shift;
`else
  assign word_push = sreg_shift;
  logic unused_swap;
  assign unused_swap = ^word_swapped;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (xfer_words == '0)       state_next = ST_FINISH;
          else if (dummy_beats != '0) state_next = ST_DUMMY;
          else                        state_next = ST_SHIFT;
        end
      end
      ST_DUMMY:  if (sample_strobe && dummy_cnt_reg == DCNT_W'(1)) state_next = ST_SHIFT;
      ST_SHIFT:  if (last_beat && last_word) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy while receiving, done only in the FINISH cycle.
  always_comb begin
    busy = (state_reg == ST_DUMMY) || (state_reg == ST_SHIFT);
    done = (state_reg == ST_FINISH);
  end

  // Config latch, dummy/beat/word counters and the assembly shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg      <= 2'd0;
      lsb_reg       <= 1'b0;
      xfer_reg      <= '0;
      dummy_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      sreg_reg      <= '0;
    end else if (start_acc) begin
      mode_reg      <= mode;
      lsb_reg       <= lsb_first;
      xfer_reg      <= xfer_words;
      dummy_cnt_reg <= dummy_beats;
      beat_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      sreg_reg      <= '0;
    end else if (state_reg == ST_DUMMY && sample_strobe) begin
      dummy_cnt_reg <= dummy_cnt_reg - DCNT_W'(1);
    end else if (strobe_shift) begin
      sreg_reg <= sreg_shift;
      if (last_beat) begin
        beat_cnt_reg <= '0;
        word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
      end else begin
        beat_cnt_reg <= beat_cnt_reg + BCNT_W'(1);
      end
    end
  end

  assign push = last_beat;
  assign pop  = head_vld_reg && out_if.ready_in;

  // Two-entry output buffer: head drives the bus, tail holds the second word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      head_vld_reg <= 1'b0;
      tail_vld_reg <= 1'b0;
    end else if (push && pop) begin
      if (tail_vld_reg) begin
        head_reg <= tail_reg;
        tail_reg <= word_push;
      end else begin
        head_reg <= word_push;
      end
    end else if (push) begin
      if (!head_vld_reg) begin
        head_reg     <= word_push;
        head_vld_reg <= 1'b1;
      end else if (!tail_vld_reg) begin
        tail_reg     <= word_push;
        tail_vld_reg <= 1'b1;
      end
    end else if (pop) begin
      if (tail_vld_reg) begin
        head_reg     <= tail_reg;
        tail_vld_reg <= 1'b0;
      end else begin
        head_vld_reg <= 1'b0;
      end
    end
  end

  // Sticky overflow: a word arrived with both entries full and nothing leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              overflow_reg <= 1'b0;
    else if (start_acc)                                   overflow_reg <= 1'b0;
    else if (push && head_vld_reg && tail_vld_reg && !pop) overflow_reg <= 1'b1;
  end

  assign overflow         = overflow_reg;
  assign out_if.data_out  = head_reg;
  assign out_if.valid_out = head_vld_reg;

endmodule

// File: tb/tb_ai_mc_rx_deserializer.sv
// Directed self-checking bench for ai_mc_rx_deserializer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ai_mc_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        lsb_first;
  logic [15:0] xfer_words;
  logic [7:0]  dummy_beats;
  logic        sample_strobe;
  logic [3:0]  miso;
  logic        busy, done, overflow;
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
  logic        byte_swap;
`endif

  int checks   = 0;
  int failures = 0;

  ai_mc_rx_deserializer_if #(.DATA_W(32)) out_if ();

  ai_mc_rx_deserializer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .lsb_first     (lsb_first),
    .xfer_words    (xfer_words),
    .dummy_beats   (dummy_beats),
    .sample_strobe (sample_strobe),
    .miso          (miso),
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
    .byte_swap     (byte_swap),
`endif
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .out_if        (out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe cycle carrying lane value v; returns at the next falling edge.
  task automatic beat(input logic [3:0] v);
    sample_strobe = 1'b1;
    miso          = v;
    @(negedge clk);
    sample_strobe = 1'b0;
    miso          = 4'h0;
  endtask

  task automatic start_xfer(input logic [1:0] m, input logic l,
                            input logic [15:0] w, input logic [7:0] d);
    start       = 1'b1;
    mode        = m;
    lsb_first   = l;
    xfer_words  = w;
    dummy_beats = d;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Eight quad beats, most significant nibble first.
  task automatic quad_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) beat(w[31-4*i -: 4]);
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp1;
    int n;
    rst = 1'b1; start = 1'b0; mode = 2'd0; lsb_first = 1'b0;
    xfer_words = '0; dummy_beats = '0; sample_strobe = 1'b0; miso = 4'h0;
    out_if.ready_in = 1'b1;
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
    byte_swap = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_data", out_if.data_out, 32'h0);
    chk("rst_valid", {31'b0, out_if.valid_out}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single lane MSB-first word.
    $display("t1 single lane msb word");
    pat  = 32'hA5C3_0F96;
    exp1 = 32'hA5C3_0F96;
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
    byte_swap = 1'b1;
    exp1 = 32'h960F_C3A5;
`endif
    start_xfer(2'd0, 1'b0, 16'd1, 8'd0);
`ifdef AI_MC_RX_DESER_BYTE_SWAP_EN
    byte_swap = 1'b0;
`endif
    chk("t1_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 31; i++) beat({3'b000, pat[31-i]});
    chk("t1_not_yet_valid", {31'b0, out_if.valid_out}, 32'h0);
    beat({3'b000, pat[0]});
    chk("t1_data", out_if.data_out, exp1);
    chk("t1_valid", {31'b0, out_if.valid_out}, 32'h1);
    chk("t1_done", {31'b0, done}, 32'h1);
    chk("t1_busy_done", {31'b0, busy}, 32'h0);
    chk("t1_ovf", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    chk("t1_done_pulse", {31'b0, done}, 32'h0);
    chk("t1_drained", {31'b0, out_if.valid_out}, 32'h0);

    // Test 2: quad lanes with 8 dummy beats, two words.
    $display("t2 quad dummy=8 two words");
    start_xfer(2'd2, 1'b0, 16'd2, 8'd8);
    for (int i = 0; i < 8; i++) beat(4'hF);
    chk("t2_busy_after_dummy", {31'b0, busy}, 32'h1);
    quad_word(32'h1234_5678);
    chk("t2_word0", out_if.data_out, 32'h1234_5678);
    chk("t2_word0_valid", {31'b0, out_if.valid_out}, 32'h1);
    chk("t2_no_done_early", {31'b0, done}, 32'h0);
    quad_word(32'h8765_4321);
    chk("t2_word1", out_if.data_out, 32'h8765_4321);
    chk("t2_done", {31'b0, done}, 32'h1);
    @(negedge clk);

    // Test 3: dual lanes LSB-first.
    $display("t3 dual lsb word");
    start_xfer(2'd1, 1'b1, 16'd1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      beat(4'b0001); beat(4'b0010); beat(4'b0011); beat(4'b0000);
    end
    chk("t3_data", out_if.data_out, 32'h3939_3939);
    chk("t3_done", {31'b0, done}, 32'h1);
    @(negedge clk);

    // Test 4: stalled output, third word overflows.
    $display("t4 overflow with ready low");
    out_if.ready_in = 1'b0;
    start_xfer(2'd2, 1'b0, 16'd3, 8'd0);
    quad_word(32'hAAAA_AAAA);
    chk("t4_w0", out_if.data_out, 32'hAAAA_AAAA);
    quad_word(32'hBBBB_BBBB);
    chk("t4_ovf_not_yet", {31'b0, overflow}, 32'h0);
    quad_word(32'hCCCC_CCCC);
    chk("t4_ovf", {31'b0, overflow}, 32'h1);
    chk("t4_done", {31'b0, done}, 32'h1);
    chk("t4_head_kept", out_if.data_out, 32'hAAAA_AAAA);
    out_if.ready_in = 1'b1;
    @(negedge clk);
    chk("t4_drain1", out_if.data_out, 32'hBBBB_BBBB);
    chk("t4_drain1_valid", {31'b0, out_if.valid_out}, 32'h1);
    chk("t4_ovf_sticky", {31'b0, overflow}, 32'h1);
    @(negedge clk);
    chk("t4_drained", {31'b0, out_if.valid_out}, 32'h0);
    start_xfer(2'd0, 1'b0, 16'd0, 8'd0);
    chk("t4_ovf_cleared", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Test 5: push and pop in the same cycle with the buffer full.
    $display("t5 push+pop while full");
    out_if.ready_in = 1'b0;
    start_xfer(2'd2, 1'b0, 16'd3, 8'd0);
    quad_word(32'hDDDD_DDDD);
    quad_word(32'hEEEE_EEEE);
    for (int i = 0; i < 7; i++) beat(4'(i + 1));
    out_if.ready_in = 1'b1;
    beat(4'h8);
    chk("t5_ovf", {31'b0, overflow}, 32'h0);
    chk("t5_head", out_if.data_out, 32'hEEEE_EEEE);
    chk("t5_done", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("t5_next", out_if.data_out, 32'h1234_5678);
    chk("t5_next_valid", {31'b0, out_if.valid_out}, 32'h1);
    @(negedge clk);
    chk("t5_empty", {31'b0, out_if.valid_out}, 32'h0);

    // Test 5b: start while busy must not change the running transfer.
    $display("t5b start while busy ignored");
    start_xfer(2'd2, 1'b0, 16'd1, 8'd0);
    beat(4'h1); beat(4'h2);
    start_xfer(2'd0, 1'b1, 16'd5, 8'd3);
    for (int i = 3; i <= 8; i++) beat(4'(i));
    chk("t5b_data", out_if.data_out, 32'h1234_5678);
    chk("t5b_done", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("t5b_idle", {31'b0, busy}, 32'h0);

    // Test 5c: zero-word transfer finishes without consuming strobes.
    $display("t5c zero words");
    start_xfer(2'd2, 1'b0, 16'd0, 8'd0);
    n = 0;
    while (!done && n < 2) begin
      beat(4'hF);
      n++;
    end
    chk("t5c_done", {31'b0, done}, 32'h1);
    chk("t5c_no_busy", {31'b0, busy}, 32'h0);
    chk("t5c_no_word", {31'b0, out_if.valid_out}, 32'h0);
    @(negedge clk);
    chk("t5c_done_pulse", {31'b0, done}, 32'h0);

    // Test 6: asynchronous reset in the middle of a word.
    $display("t6 reset mid-word");
    out_if.ready_in = 1'b0;
    start_xfer(2'd2, 1'b0, 16'd2, 8'd0);
    quad_word(32'h1234_5678);
    beat(4'h9); beat(4'h9); beat(4'h9);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_data", out_if.data_out, 32'h0);
    chk("t6_rst_valid", {31'b0, out_if.valid_out}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy}, 32'h0);
    chk("t6_rst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_if.ready_in = 1'b1;
    @(negedge clk);
    start_xfer(2'd2, 1'b0, 16'd1, 8'd0);
    quad_word(32'h8765_4321);
    chk("t6_after_rst_data", out_if.data_out, 32'h8765_4321);
    chk("t6_after_rst_done", {31'b0, done}, 32'h1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
